// File: rtl/lab3_keypad_scan_pkg.sv
// Shared types and constants for the 4x4 keypad scanner and its code decoder.
package lab3_pkg;

    typedef enum logic [1:0] {
        SCAN     = 2'd0,
        DEBOUNCE = 2'd1,
        HOLD     = 2'd2,
        RELEASE  = 2'd3
    } state_t;

    // Key codes indexed [row][col]. The first entry is row 0, col 0.
    localparam logic [0:3][0:3][3:0] KEY_LUT = {
        4'h1, 4'h2, 4'h3, 4'hA,
        4'h4, 4'h5, 4'h6, 4'hB,
        4'h7, 4'h8, 4'h9, 4'hC,
        4'hE, 4'h0, 4'hF, 4'hD
    };

    // Returns the lowest-numbered row that reads low (active-low rows).
    function automatic logic [1:0] low_row(input logic [3:0] rows);
        logic [1:0] idx;
        if (!rows[0])      idx = 2'd0;
        else if (!rows[1]) idx = 2'd1;
        else if (!rows[2]) idx = 2'd2;
        else               idx = 2'd3;
        return idx;
    endfunction

endpackage

// File: rtl/lab3_keypad_decode.sv
// Combinational (row, col) to hex key code lookup. The display block also
// uses this decoder to generate test patterns.
module lab3_keypad_decode
    import lab3_pkg::*;
(
    input  logic [1:0] i_row_idx,
    input  logic [1:0] i_col_idx,
    output logic [3:0] o_code
);

    assign o_code = KEY_LUT[i_row_idx][i_col_idx];

endmodule

// File: rtl/lab3_keypad_scan.sv
// 4x4 keypad column scanner with press/release debounce.
// Optional macro KEYPAD_REPEAT_EN: while a key is held, key_valid re-pulses
// every REPEAT_CYCLES cycles.
//
// state    | meaning
// ---------+------------------------------------------------------------
// SCAN     | drive one column per dwell period, sample rows at its end
// DEBOUNCE | row seen low; wait for DEBOUNCE_CYCLES of stable low
// HOLD     | key accepted; column frozen until the row goes high
// RELEASE  | row seen high; wait for DEBOUNCE_CYCLES of stable high
module lab3_keypad_scan #(
    parameter int SCAN_DIV        = 4096,
    parameter int DEBOUNCE_CYCLES = 20000
`ifdef KEYPAD_REPEAT_EN
    ,
    parameter int REPEAT_CYCLES   = 2000000
`endif
) (
    input  logic       int_osc,
    input  logic       reset,
    input  logic [3:0] rows_sync,
    output logic [3:0] cols,
    output logic [3:0] key,
    output logic       key_valid
);
    import lab3_pkg::*;

    localparam int DW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] DEB_LAST   = CW'(DEBOUNCE_CYCLES - 1);

    state_t         r_state, w_state_nxt;
    logic [1:0]     r_col, w_col_nxt;
    logic [1:0]     r_row, w_row_nxt;
    logic [DW-1:0]  r_dwell, w_dwell_nxt;
    logic [CW-1:0]  r_cnt, w_cnt_nxt;
    logic [3:0]     r_key, w_key_nxt;
    logic           r_valid, w_valid_nxt;
    logic [3:0]     w_code;
    logic           w_row_low;

`ifdef KEYPAD_REPEAT_EN
    localparam int RW = (REPEAT_CYCLES > 1) ? $clog2(REPEAT_CYCLES) : 1;
    localparam logic [RW-1:0] REP_LAST = RW'(REPEAT_CYCLES - 1);
    logic [RW-1:0]  r_rep, w_rep_nxt;
`endif

    lab3_keypad_decode u_decode (
        .i_row_idx (r_row),
        .i_col_idx (r_col),
        .o_code    (w_code)
    );

    assign w_row_low = ~rows_sync[r_row];
    assign cols      = ~(4'b0001 << r_col);
    assign key       = r_key;
    assign key_valid = r_valid;

    // State and datapath registers; reset parks the scanner on column 0.
    always_ff @(posedge int_osc or negedge reset) begin
        if (!reset) begin
            r_state <= SCAN;
            r_col   <= 2'd0;
            r_row   <= 2'd0;
            r_dwell <= '0;
            r_cnt   <= '0;
            r_key   <= 4'h0;
            r_valid <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
            r_rep   <= '0;
`endif
        end else begin
            r_state <= w_state_nxt;
            r_col   <= w_col_nxt;
            r_row   <= w_row_nxt;
            r_dwell <= w_dwell_nxt;
            r_cnt   <= w_cnt_nxt;
            r_key   <= w_key_nxt;
            r_valid <= w_valid_nxt;
`ifdef KEYPAD_REPEAT_EN
            r_rep   <= w_rep_nxt;
`endif
        end
    end

    // Next-state and counter logic; the strobe defaults low so it lasts one cycle.
    always_comb begin
        w_state_nxt = r_state;
        w_col_nxt   = r_col;
        w_row_nxt   = r_row;
        w_dwell_nxt = r_dwell;
        w_cnt_nxt   = r_cnt;
        w_key_nxt   = r_key;
        w_valid_nxt = 1'b0;
`ifdef KEYPAD_REPEAT_EN
        // Cleared everywhere except while counting inside HOLD.
        w_rep_nxt   = '0;
`endif
        case (r_state)
            SCAN: begin
                if (r_dwell == DWELL_LAST) begin
                    w_dwell_nxt = '0;
                    if (rows_sync == 4'hF) begin
                        w_col_nxt = r_col + 2'd1;
                    end else begin
                        w_row_nxt   = low_row(rows_sync);
                        w_cnt_nxt   = '0;
                        w_state_nxt = DEBOUNCE;
                    end
                end else begin
                    w_dwell_nxt = r_dwell + 1'b1;
                end
            end
            DEBOUNCE: begin
                if (w_row_low) begin
                    if (r_cnt == DEB_LAST) begin
                        w_key_nxt   = w_code;
                        w_valid_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                        w_state_nxt = HOLD;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_col_nxt   = r_col + 2'd1;
                    w_dwell_nxt = '0;
                    w_state_nxt = SCAN;
                end
            end
            HOLD: begin
                if (!w_row_low) begin
                    w_cnt_nxt   = '0;
                    w_state_nxt = RELEASE;
                end
`ifdef KEYPAD_REPEAT_EN
                else if (r_rep == REP_LAST) begin
                    w_valid_nxt = 1'b1;
                end else begin
                    w_rep_nxt = r_rep + 1'b1;
                end
`endif
            end
            RELEASE: begin
                if (!w_row_low) begin
                    if (r_cnt == DEB_LAST) begin
                        w_cnt_nxt   = '0;
                        w_col_nxt   = r_col + 2'd1;
                        w_dwell_nxt = '0;
                        w_state_nxt = SCAN;
                    end else begin
                        w_cnt_nxt = r_cnt + 1'b1;
                    end
                end else begin
                    w_state_nxt = HOLD;
                end
            end
            default: w_state_nxt = SCAN;
        endcase
    end

endmodule
